// File: rtl/bpu_btac_pht.sv
// Fetch-side branch predictor storage: 4-entry fully-associative BTAC, gshare PHT and GHR,
// fed by a small queue of resolved-branch updates that drains when lookups leave room.
module bpu_btac_pht #(
  parameter int unsigned PHT_IDX_WIDTH = 11,
  parameter int unsigned BTAC_DEPTH    = 4,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_exu_iq_btac_vld,
  output logic                     o_iq_exu_upd_rdy,
  input  logic                     i_exu_iq_btac_taken,
  input  logic                     i_exu_iq_btac_new_br,
  input  logic                     i_exu_iq_type,
  input  logic [31:0]              i_exu_iq_btac_addr,
  input  logic [31:0]              i_exu_iq_btac_taddr,
  input  logic [1:0]               i_exu_iq_btac_idx,
  input  logic [PHT_IDX_WIDTH-1:0] i_exu_iq_pht_idx,
  input  logic [1:0]               i_exu_iq_pht_status,
  input  logic                     i_exu_iq_len,
  input  logic                     i_exu_iq_tsucc,
  input  logic                     i_ifu_bpu_vld,
  input  logic [31:0]              i_ifu_bpu_pc,
  output logic                     o_bpu_ifu_stall,
  output logic                     o_bpu_ifu_hit,
  output logic                     o_bpu_ifu_taken,
  output logic [31:0]              o_bpu_ifu_taddr,
  output logic                     o_bpu_ifu_len,
  output logic [PHT_IDX_WIDTH+7:0] o_bpu_ifu_predinfo
);

  localparam int unsigned PhtSize = 1 << PHT_IDX_WIDTH;
  localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned StvW    = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic                     taken;
    logic                     new_br;
    logic                     jump;
    logic                     len;
    logic                     tsucc;
    logic [31:0]              addr;
    logic [31:0]              taddr;
    logic [1:0]               btac_idx;
    logic [PHT_IDX_WIDTH-1:0] pht_idx;
    logic [1:0]               status;
  } upd_t;

  upd_t                     fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [StvW-1:0]          starve_q, starve_d;
  logic [PHT_IDX_WIDTH-1:0] ghr_q, ghr_d;
  logic [1:0]               rr_q, rr_d;
  logic [1:0]               pht_q [PhtSize];

  logic        btac_vld_q   [BTAC_DEPTH], btac_vld_d   [BTAC_DEPTH];
  logic [31:0] btac_tag_q   [BTAC_DEPTH], btac_tag_d   [BTAC_DEPTH];
  logic [31:0] btac_taddr_q [BTAC_DEPTH], btac_taddr_d [BTAC_DEPTH];
  logic        btac_jmp_q   [BTAC_DEPTH], btac_jmp_d   [BTAC_DEPTH];
  logic        btac_len_q   [BTAC_DEPTH], btac_len_d   [BTAC_DEPTH];

  logic                     full, nonempty, enq, drain, stall;
  upd_t                     head, incoming;
  logic                     pht_we;
  logic [1:0]               pht_wdata;
  logic                     upd_match;
  logic [1:0]               upd_sel, btac_widx;
  logic [PHT_IDX_WIDTH-1:0] lk_idx;
  logic [1:0]               lk_status, lk_sel;
  logic                     lk_match;

  always_comb begin
    incoming = '{taken: i_exu_iq_btac_taken, new_br: i_exu_iq_btac_new_br, jump: i_exu_iq_type,
                 len: i_exu_iq_len, tsucc: i_exu_iq_tsucc, addr: i_exu_iq_btac_addr,
                 taddr: i_exu_iq_btac_taddr, btac_idx: i_exu_iq_btac_idx,
                 pht_idx: i_exu_iq_pht_idx, status: i_exu_iq_pht_status};
    full     = (cnt_q == CntW'(FIFO_DEPTH));
    nonempty = (cnt_q != '0);
    stall    = (starve_q == StvW'(STARVE_LIMIT));
    enq      = i_exu_iq_btac_vld & ~full;
    drain    = nonempty & (~i_ifu_bpu_vld | stall);
    head     = fifo_q[rd_ptr_q];

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq)   wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (drain) rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CntW'(enq) - CntW'(drain);
    // Non-empty without a drain means a lookup was served while updates waited.
    starve_d = (nonempty & ~drain) ? starve_q + 1'b1 : '0;
  end

  // Apply the queue head: PHT/GHR for conditionals, BTAC for taken new or mispredicted branches.
  always_comb begin
    pht_we    = drain & ~head.jump;
    pht_wdata = head.status;
    if (head.taken && head.status != 2'b11)      pht_wdata = head.status + 2'b01;
    else if (!head.taken && head.status != 2'b00) pht_wdata = head.status - 2'b01;
    ghr_d = pht_we ? {ghr_q[PHT_IDX_WIDTH-2:0], head.taken} : ghr_q;

    upd_match = 1'b0;
    upd_sel   = '0;
    for (int i = 0; i < BTAC_DEPTH; i++) begin
      if (btac_vld_q[i] && btac_tag_q[i] == head.addr) begin
        upd_match = 1'b1;
        upd_sel   = 2'(i);
      end
    end
    btac_widx    = upd_match ? upd_sel : rr_q;
    rr_d         = rr_q;
    btac_vld_d   = btac_vld_q;
    btac_tag_d   = btac_tag_q;
    btac_taddr_d = btac_taddr_q;
    btac_jmp_d   = btac_jmp_q;
    btac_len_d   = btac_len_q;
    if (drain && head.new_br && head.taken) begin
      if (!upd_match) rr_d = rr_q + 2'b01;
      btac_vld_d[btac_widx]   = 1'b1;
      btac_tag_d[btac_widx]   = head.addr;
      btac_taddr_d[btac_widx] = head.taddr;
      btac_jmp_d[btac_widx]   = head.jump;
      btac_len_d[btac_widx]   = head.len;
    end else if (drain && !head.new_br && head.taken && !head.tsucc) begin
      btac_taddr_d[head.btac_idx] = head.taddr;
    end
  end

  always_comb begin
    lk_idx    = i_ifu_bpu_pc[PHT_IDX_WIDTH+1:2] ^ ghr_q;
    lk_status = pht_q[lk_idx];
    lk_match  = 1'b0;
    lk_sel    = '0;
    for (int i = 0; i < BTAC_DEPTH; i++) begin
      if (btac_vld_q[i] && btac_tag_q[i] == i_ifu_bpu_pc) begin
        lk_match = 1'b1;
        lk_sel   = 2'(i);
      end
    end
    o_iq_exu_upd_rdy = ~full;
    o_bpu_ifu_stall  = stall;
    o_bpu_ifu_hit    = i_ifu_bpu_vld & ~stall & lk_match;
    o_bpu_ifu_taken  = o_bpu_ifu_hit & (btac_jmp_q[lk_sel] | lk_status[1]);
    o_bpu_ifu_taddr  = o_bpu_ifu_hit ? btac_taddr_q[lk_sel] : '0;
    o_bpu_ifu_len    = o_bpu_ifu_hit & btac_len_q[lk_sel];
    o_bpu_ifu_predinfo = stall ? '0 : {o_bpu_ifu_hit, 1'b0, o_bpu_ifu_hit ? lk_sel : 2'b00,
                                       lk_idx, lk_status, 1'b0, o_bpu_ifu_taken};
  end

  always_ff @(posedge clk) begin
    if (enq) fifo_q[wr_ptr_q] <= incoming;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      ghr_q    <= '0;
      rr_q     <= '0;
      for (int i = 0; i < BTAC_DEPTH; i++) begin
        btac_vld_q[i]   <= 1'b0;
        btac_tag_q[i]   <= '0;
        btac_taddr_q[i] <= '0;
        btac_jmp_q[i]   <= 1'b0;
        btac_len_q[i]   <= 1'b0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      ghr_q        <= ghr_d;
      rr_q         <= rr_d;
      btac_vld_q   <= btac_vld_d;
      btac_tag_q   <= btac_tag_d;
      btac_taddr_q <= btac_taddr_d;
      btac_jmp_q   <= btac_jmp_d;
      btac_len_q   <= btac_len_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PhtSize; i++) pht_q[i] <= 2'b01;
    end else if (pht_we) begin
      pht_q[head.pht_idx] <= pht_wdata;
    end
  end

endmodule

// File: tb/tb_bpu_btac_pht.sv
// Directed bench for bpu_btac_pht: lookup, update application, replacement, saturation,
// queue backpressure, starvation stalls and asynchronous reset.
module tb_bpu_btac_pht;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_vld, upd_rdy, upd_taken, upd_new_br, upd_type, upd_len, upd_tsucc;
  logic [31:0] upd_addr, upd_taddr;
  logic [1:0]  upd_bidx, upd_status;
  logic [10:0] upd_pidx;
  logic        lk_vld, stall, hit, taken, len;
  logic [31:0] lk_pc, taddr;
  logic [18:0] predinfo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bpu_btac_pht dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_exu_iq_btac_vld    (upd_vld),
    .o_iq_exu_upd_rdy     (upd_rdy),
    .i_exu_iq_btac_taken  (upd_taken),
    .i_exu_iq_btac_new_br (upd_new_br),
    .i_exu_iq_type        (upd_type),
    .i_exu_iq_btac_addr   (upd_addr),
    .i_exu_iq_btac_taddr  (upd_taddr),
    .i_exu_iq_btac_idx    (upd_bidx),
    .i_exu_iq_pht_idx     (upd_pidx),
    .i_exu_iq_pht_status  (upd_status),
    .i_exu_iq_len         (upd_len),
    .i_exu_iq_tsucc       (upd_tsucc),
    .i_ifu_bpu_vld        (lk_vld),
    .i_ifu_bpu_pc         (lk_pc),
    .o_bpu_ifu_stall      (stall),
    .o_bpu_ifu_hit        (hit),
    .o_bpu_ifu_taken      (taken),
    .o_bpu_ifu_taddr      (taddr),
    .o_bpu_ifu_len        (len),
    .o_bpu_ifu_predinfo   (predinfo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic nb, input logic tk, input logic jmp, input logic ln,
                     input logic ts, input logic [31:0] a, input logic [31:0] ta,
                     input logic [1:0] bi, input logic [10:0] pi, input logic [1:0] st);
    upd_vld = 1'b1; upd_new_br = nb; upd_taken = tk; upd_type = jmp; upd_len = ln;
    upd_tsucc = ts; upd_addr = a; upd_taddr = ta; upd_bidx = bi; upd_pidx = pi;
    upd_status = st;
  endtask

  task automatic no_upd();
    upd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 11'd0, 2'd0);
    upd_vld = 1'b0;
  endtask

  // Lookup in a fresh cycle, sampled 1 ns after the falling edge.
  task automatic probe(input logic [31:0] pc);
    @(negedge clk);
    lk_vld = 1'b1;
    lk_pc  = pc;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    no_upd();
    lk_vld = 1'b1;
    lk_pc  = 32'h100;
    #2;
    check("reset_rdy", upd_rdy, 1);
    check("reset_stall", stall, 0);
    check("reset_hit", hit, 0);
    check("reset_taken", taken, 0);
    check("reset_taddr", taddr, 0);
    check("reset_len", len, 0);
    check("reset_predinfo", predinfo, 32'h404);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // New conditional branch, then lookup.
    lk_vld = 1'b0;
    upd(1, 1, 0, 1, 0, 32'h100, 32'h200, 2'd0, 11'h40, 2'd1);
    #1 check("t1_rdy", upd_rdy, 1);
    @(negedge clk);
    no_upd();
    @(negedge clk);
    probe(32'h100);
    check("t1_hit", hit, 1);
    check("t1_taken", taken, 0);
    check("t1_taddr", taddr, 32'h200);
    check("t1_len", len, 1);
    check("t1_predinfo", predinfo, 32'h40414);
    probe(32'h104);
    check("t1_pht40_ghr1", predinfo, 32'h408);

    // Jump insert, then target correction of entry 1.
    @(negedge clk);
    lk_vld = 1'b0;
    upd(1, 1, 1, 0, 0, 32'h300, 32'h400, 2'd0, 11'h0, 2'd0);
    @(negedge clk);
    upd(0, 1, 1, 0, 0, 32'h300, 32'h500, 2'd1, 11'h0, 2'd0);
    @(negedge clk);
    no_upd();
    @(negedge clk);
    probe(32'h300);
    check("t2_hit", hit, 1);
    check("t2_taken", taken, 1);
    check("t2_taddr", taddr, 32'h500);
    check("t2_len", len, 0);
    check("t2_predinfo", predinfo, 32'h48C15);

    // Replacement from a clean state.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lk_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      upd(1, 1, 1, 1, 0, 32'h1000 + 32'(4 * i), 32'h2000 + 32'(16 * i), 2'd0, 11'h0, 2'd0);
      @(negedge clk);
    end
    no_upd();
    @(negedge clk);
    probe(32'h1000);
    check("t3_first_evicted", hit, 0);
    probe(32'h1010);
    check("t3_fifth_hit", hit, 1);
    check("t3_fifth_taddr", taddr, 32'h2040);
    check("t3_fifth_idx", predinfo[16:15], 0);
    check("t3_fifth_predinfo", predinfo, 32'h44045);
    probe(32'h100C);
    check("t3_fourth_idx", predinfo[16:15], 3);
    @(negedge clk);
    lk_vld = 1'b0;
    upd(1, 1, 1, 1, 0, 32'h1008, 32'h7770, 2'd0, 11'h0, 2'd0);
    @(negedge clk);
    upd(1, 1, 1, 1, 0, 32'h1014, 32'h2050, 2'd0, 11'h0, 2'd0);
    @(negedge clk);
    no_upd();
    @(negedge clk);
    probe(32'h1008);
    check("t3_reinsert_idx", predinfo[16:15], 2);
    check("t3_reinsert_taddr", taddr, 32'h7770);
    probe(32'h1014);
    check("t3_sixth_hit", hit, 1);
    check("t3_sixth_idx_rr_kept", predinfo[16:15], 1);
    probe(32'h1004);
    check("t3_second_evicted", hit, 0);

    // Saturation, using carried status rather than the array value.
    @(negedge clk);
    lk_vld = 1'b0;
    upd(0, 1, 0, 1, 1, 32'h0, 32'h0, 2'd0, 11'h10, 2'd3);
    @(negedge clk);
    upd(0, 0, 0, 1, 1, 32'h0, 32'h0, 2'd0, 11'h20, 2'd0);
    @(negedge clk);
    no_upd();
    @(negedge clk);
    probe(32'h48);
    check("t4_sat_hi_idx", predinfo[14:4], 32'h10);
    check("t4_sat_hi", predinfo[3:2], 3);
    probe(32'h88);
    check("t4_sat_lo_idx", predinfo[14:4], 32'h20);
    check("t4_sat_lo", predinfo[3:2], 0);

    // Backpressure and starvation with lookups held on a hitting PC.
    for (int s = 0; s < 20; s++) begin
      logic exp_stall, exp_rdy;
      @(negedge clk);
      lk_vld = 1'b1;
      lk_pc  = 32'h1010;
      if (s == 0)      upd(0, 1, 0, 1, 1, 32'h0, 32'h0, 2'd0, 11'h30, 2'd1);
      else if (s == 1) upd(0, 1, 0, 1, 1, 32'h0, 32'h0, 2'd0, 11'h31, 2'd1);
      else if (s == 2) upd(1, 1, 1, 1, 0, 32'hA000, 32'hB000, 2'd0, 11'h0, 2'd0);
      else             no_upd();
      #1;
      exp_stall = (s == 9) || (s == 18);
      exp_rdy   = !(s >= 2 && s <= 9);
      check($sformatf("t5_stall_c%0d", s), stall, exp_stall);
      check($sformatf("t5_rdy_c%0d", s), upd_rdy, exp_rdy);
      check($sformatf("t5_hit_c%0d", s), hit, !exp_stall);
      if (exp_stall) check($sformatf("t5_predinfo_c%0d", s), predinfo, 0);
    end
    probe(32'h0);
    check("t5_ghr_after_two", predinfo[14:4], 32'hB);
    probe(32'hEC);
    check("t5_pht30", predinfo[3:2], 2);
    probe(32'hA000);
    check("t5_dropped_miss", hit, 0);

    // Asynchronous reset in a drain cycle with the queue full.
    @(negedge clk);
    lk_vld = 1'b1;
    lk_pc  = 32'h1010;
    upd(1, 1, 1, 1, 0, 32'hB000, 32'hC000, 2'd0, 11'h0, 2'd0);
    @(negedge clk);
    upd(1, 1, 1, 1, 0, 32'hB100, 32'hC100, 2'd0, 11'h0, 2'd0);
    @(negedge clk);
    no_upd();
    #1 check("t6_full_rdy", upd_rdy, 0);
    lk_vld = 1'b0;
    #1;
    rst    = 1'b1;
    lk_vld = 1'b1;
    #1;
    check("t6_rst_rdy", upd_rdy, 1);
    check("t6_rst_stall", stall, 0);
    check("t6_rst_hit", hit, 0);
    check("t6_rst_taddr", taddr, 0);
    check("t6_rst_predinfo", predinfo, 32'h4044);
    @(negedge clk);
    rst = 1'b0;
    probe(32'hB000);
    check("t6_post_miss_b000", hit, 0);
    probe(32'h1010);
    check("t6_post_miss_1010", hit, 0);
    check("t6_post_rdy", upd_rdy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
